vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_edge_detect.sv | 28 ++
 rtl/vga_sync_receiver.sv | 252 +++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, receiver state encoding and small
// counter helpers used by the sync receiver and the display controller.
package vga_timing_pkg;

   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned H_SYNC      = 96;
   localparam int unsigned H_ACT_START = 144;
   localparam int unsigned H_ACT_END   = 783;
   localparam int unsigned V_TOTAL     = 525;
   localparam int unsigned V_SYNC      = 2;
   localparam int unsigned V_ACT_START = 35;
   localparam int unsigned V_ACT_END   = 514;

   localparam logic [9:0] CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } sync_state_t;

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == CNT_MAX) ? v : v + 10'd1;
   endfunction

   function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Enable-qualified sampling of one active-low sync with fall/rise pulses;
// the history idles high so a sync held low out of reset reads as a fall.
module vga_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync,
   output logic fall,
   output logic rise
);

   logic prev_r;

   // Sync history, advanced only on enabled samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_r <= 1'b1;
      end else if (en) begin
         prev_r <= sync;
      end else begin
         prev_r <= prev_r;
      end
   end

   assign fall = en & prev_r & ~sync;
   assign rise = en & ~prev_r & sync;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers raw position from the syncs, checks line/frame
// timing, tracks lock and latches a per-frame RGB checksum of locked frames.
module vga_sync_receiver
   import vga_timing_pkg::*;
#(
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned ERR_W       = 8,
   parameter int unsigned H_TOT       = H_TOTAL,
   parameter int unsigned H_SYN       = H_SYNC,
   parameter int unsigned H_ACT_LO    = H_ACT_START,
   parameter int unsigned H_ACT_HI    = H_ACT_END,
   parameter int unsigned V_TOT       = V_TOTAL,
   parameter int unsigned V_SYN       = V_SYNC,
   parameter int unsigned V_ACT_LO    = V_ACT_START,
   parameter int unsigned V_ACT_HI    = V_ACT_END
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vga_clk,
   input  logic             hor_sync,
   input  logic             ver_sync,
   input  logic [7:0]       red,
   input  logic [7:0]       green,
   input  logic [7:0]       blue,
   output logic [9:0]       x,
   output logic [9:0]       y,
   output logic             pix_valid,
   output logic [9:0]       pix_x,
   output logic [9:0]       pix_y,
   output logic [23:0]      pix_rgb,
   output logic             locked,
   output logic             line_err,
   output logic             frame_err,
   output logic [ERR_W-1:0] err_count,
   output logic [15:0]      frame_sum,
   output logic             frame_done
);

   localparam logic [9:0] X_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] Y_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] H_SYN_W = 10'(H_SYN);
   localparam logic [9:0] V_SYN_W = 10'(V_SYN);
   localparam logic [9:0] H_LO_W  = 10'(H_ACT_LO);
   localparam logic [9:0] H_HI_W  = 10'(H_ACT_HI);
   localparam logic [9:0] V_LO_W  = 10'(V_ACT_LO);
   localparam logic [9:0] V_HI_W  = 10'(V_ACT_HI);
   localparam int unsigned TALLY_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
   localparam logic [TALLY_W-1:0] LOCK_LAST = TALLY_W'(LOCK_FRAMES - 1);
   localparam int unsigned ERR_W1 = ERR_W + 1;

   logic              h_fall_s, h_rise_s, v_fall_s, v_rise_s;
   logic [9:0]        x_r, y_r, hlow_r, vlow_r;
   logic              h_low_r, v_low_r;
   sync_state_t       state_r;
   logic [TALLY_W-1:0] tally_r;
   logic              clean_r;
   logic [15:0]       acc_r;

   logic [9:0]        x_nxt_s, y_nxt_s;
   logic              line_bad_s, frame_bad_s, line_err_s, frame_err_s;
   logic              pix_ok_s, sum_latch_s;
   logic [15:0]       rgb_sum_s;
   logic [1:0]        err_add_s;
   logic [ERR_W1-1:0] err_sum_s;
   logic [ERR_W-1:0]  err_nxt_s;

   vga_edge_detect u_hsync (
      .clk  (clk),
      .rst  (rst),
      .en   (vga_clk),
      .sync (hor_sync),
      .fall (h_fall_s),
      .rise (h_rise_s)
   );

   vga_edge_detect u_vsync (
      .clk  (clk),
      .rst  (rst),
      .en   (vga_clk),
      .sync (ver_sync),
      .fall (v_fall_s),
      .rise (v_rise_s)
   );

   assign x = x_r;
   assign y = y_r;

   // Next position, timing checks, pixel qualification and error accounting
   always_comb begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
      if (h_fall_s) begin
         x_nxt_s = 10'd0;
      end else if (vga_clk) begin
         x_nxt_s = sat_inc(x_r);
      end else begin
         x_nxt_s = x_r;
      end
      if (v_fall_s) begin
         y_nxt_s = 10'd0;
      end else if (h_fall_s) begin
         y_nxt_s = sat_inc(y_r);
      end else begin
         y_nxt_s = y_r;
      end

      line_bad_s  = h_fall_s && ((x_r != X_LAST) || (hlow_r != H_SYN_W));
      frame_bad_s = v_fall_s && ((y_r != Y_LAST) || (vlow_r != V_SYN_W));
      line_err_s  = line_bad_s && (state_r != UNLOCKED);
      frame_err_s = frame_bad_s && (state_r != UNLOCKED);

      pix_ok_s    = vga_clk && (state_r == LOCKED) &&
                    in_window(x_nxt_s, H_LO_W, H_HI_W) &&
                    in_window(y_nxt_s, V_LO_W, V_HI_W);
      rgb_sum_s   = 16'(red) + 16'(green) + 16'(blue);
      // Being LOCKED at a vsync fall implies LOCKED since the previous one
      sum_latch_s = v_fall_s && (state_r == LOCKED) && !line_err_s && !frame_err_s;

      err_add_s = {1'b0, line_err_s} + {1'b0, frame_err_s};
      err_sum_s = {1'b0, err_count} + ERR_W1'(err_add_s);
      if (err_sum_s[ERR_W]) begin
         err_nxt_s = {ERR_W{1'b1}};
      end else begin
         err_nxt_s = err_sum_s[ERR_W-1:0];
      end
   end

   // Lock state machine with the clean-frame tally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= UNLOCKED;
         tally_r <= '0;
         clean_r <= 1'b0;
         locked  <= 1'b0;
      end else if (vga_clk) begin
         case (state_r)
            UNLOCKED: begin
               if (v_fall_s) begin
                  state_r <= ACQUIRE;
                  tally_r <= '0;
                  clean_r <= 1'b1;
               end else begin
                  state_r <= UNLOCKED;
               end
            end
            ACQUIRE: begin
               if (v_fall_s) begin
                  clean_r <= 1'b1;
                  if (line_err_s || frame_err_s || !clean_r) begin
                     tally_r <= '0;
                  end else if (tally_r == LOCK_LAST) begin
                     state_r <= LOCKED;
                     tally_r <= '0;
                     locked  <= 1'b1;
                  end else begin
                     tally_r <= tally_r + TALLY_W'(1'b1);
                  end
               end else if (line_err_s) begin
                  tally_r <= '0;
                  clean_r <= 1'b0;
               end else begin
                  tally_r <= tally_r;
               end
            end
            LOCKED: begin
               if (line_err_s || frame_err_s) begin
                  state_r <= ACQUIRE;
                  tally_r <= '0;
                  clean_r <= v_fall_s;
                  locked  <= 1'b0;
               end else begin
                  clean_r <= 1'b1;
               end
            end
            default: begin
               state_r <= UNLOCKED;
               tally_r <= '0;
               clean_r <= 1'b0;
               locked  <= 1'b0;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   // Raw counters, sync widths, pixel outputs, error pulses and checksum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r        <= 10'd0;
         y_r        <= 10'd0;
         hlow_r     <= 10'd0;
         vlow_r     <= 10'd0;
         h_low_r    <= 1'b0;
         v_low_r    <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= 10'd0;
         pix_y      <= 10'd0;
         pix_rgb    <= 24'd0;
         line_err   <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= {ERR_W{1'b0}};
         acc_r      <= 16'd0;
         frame_sum  <= 16'd0;
         frame_done <= 1'b0;
      end else begin
         x_r        <= x_nxt_s;
         y_r        <= y_nxt_s;
         pix_valid  <= pix_ok_s;
         line_err   <= line_err_s;
         frame_err  <= frame_err_s;
         err_count  <= err_nxt_s;
         frame_done <= sum_latch_s;

         if (h_fall_s) begin
            h_low_r <= 1'b1;
            hlow_r  <= 10'd1;
         end else if (h_rise_s) begin
            h_low_r <= 1'b0;
         end else if (vga_clk && h_low_r) begin
            hlow_r <= sat_inc(hlow_r);
         end

         // Vsync width is measured in lines: hsync falls seen while vsync is low
         if (v_fall_s) begin
            v_low_r <= 1'b1;
            vlow_r  <= 10'd1;
         end else if (v_rise_s) begin
            v_low_r <= 1'b0;
         end else if (h_fall_s && v_low_r) begin
            vlow_r <= sat_inc(vlow_r);
         end

         if (pix_ok_s) begin
            pix_x   <= x_nxt_s - H_LO_W;
            pix_y   <= y_nxt_s - V_LO_W;
            pix_rgb <= {red, green, blue};
         end

         if (v_fall_s) begin
            acc_r <= 16'd0;
         end else if (pix_ok_s) begin
            acc_r <= acc_r + rgb_sum_s;
         end

         if (sum_latch_s) begin
            frame_sum <= acc_r;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down 20x12 raster
// (3-pixel hsync, 2-line vsync, 12x8 active area = 96 pixels per frame).
module tb_vga_sync_receiver;

   localparam int HT = 20, HS = 3, HAL = 5, HAH = 16;
   localparam int VT = 12, VS = 2, VAL = 3, VAH = 10;

   logic        clk = 1'b0;
   logic        rst, vga_clk, hor_sync, ver_sync;
   logic [7:0]  red, green, blue;
   logic [9:0]  x, y, pix_x, pix_y;
   logic        pix_valid, locked, line_err, frame_err, frame_done;
   logic [23:0] pix_rgb;
   logic [7:0]  err_count;
   logic [15:0] frame_sum;

   int n_checks = 0;
   int n_fail   = 0;
   int div      = 1;
   int pv_cnt = 0, fd_cnt = 0, le_cnt = 0, fe_cnt = 0, both_cnt = 0;
   logic [9:0]  last_px  = 10'd0;
   logic [9:0]  last_py  = 10'd0;
   logic [23:0] last_rgb = 24'd0;

   always #5 clk = ~clk;

   vga_sync_receiver #(
      .LOCK_FRAMES (2),
      .ERR_W       (8),
      .H_TOT       (HT),
      .H_SYN       (HS),
      .H_ACT_LO    (HAL),
      .H_ACT_HI    (HAH),
      .V_TOT       (VT),
      .V_SYN       (VS),
      .V_ACT_LO    (VAL),
      .V_ACT_HI    (VAH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vga_clk    (vga_clk),
      .hor_sync   (hor_sync),
      .ver_sync   (ver_sync),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .x          (x),
      .y          (y),
      .pix_valid  (pix_valid),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_rgb    (pix_rgb),
      .locked     (locked),
      .line_err   (line_err),
      .frame_err  (frame_err),
      .err_count  (err_count),
      .frame_sum  (frame_sum),
      .frame_done (frame_done)
   );

   // Pulse counters and last valid pixel, sampled away from the active edge
   always @(negedge clk) begin
      if (pix_valid) begin
         pv_cnt   <= pv_cnt + 1;
         last_px  <= pix_x;
         last_py  <= pix_y;
         last_rgb <= pix_rgb;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (line_err) le_cnt <= le_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (line_err && frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One pixel sample, then div-1 disabled cycles; returns on a negedge
   task automatic drive(input logic h, input logic v, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
      hor_sync = h;
      ver_sync = v;
      red      = r;
      green    = g;
      blue     = b;
      vga_clk  = 1'b1;
      @(negedge clk);
      vga_clk  = 1'b0;
      for (int i = 1; i < div; i++) @(negedge clk);
   endtask

   task automatic send_frame(input int nlines, input int short_line, input bit white);
      for (int l = 0; l < nlines; l++) begin
         int len;
         len = (l == short_line) ? HT - 1 : HT;
         for (int p = 0; p < len; p++) begin
            if (white)
               drive((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, 8'hFF, 8'hFF, 8'hFF);
            else
               drive((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, 8'h01, 8'h02, 8'h03);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pv0, fd0, le0, fe0, b0;
      rst = 1'b1; vga_clk = 1'b0; hor_sync = 1'b1; ver_sync = 1'b1;
      red = 8'h00; green = 8'h00; blue = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_x", 32'(x), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      rst = 1'b0;

      // Acquire: lock rises at the third vsync fall
      pv0 = pv_cnt;
      send_frame(VT, -1, 1'b1);
      send_frame(VT, -1, 1'b1);
      check("unlocked_after_2", 32'(locked), 32'd0);
      check("no_pix_unlocked", 32'(pv_cnt - pv0), 32'd0);
      pv0 = pv_cnt;
      send_frame(VT, -1, 1'b1);
      check("locked_3rd_vfall", 32'(locked), 32'd1);
      check("x_line_end", 32'(x), 32'd19);
      check("y_frame_end", 32'(y), 32'd11);
      check("pix_count_f3", 32'(pv_cnt - pv0), 32'd96);
      check("sum_not_yet", 32'(frame_sum), 32'd0);

      // White frame checksum: 96*765 mod 65536
      pv0 = pv_cnt; fd0 = fd_cnt;
      send_frame(VT, -1, 1'b1);
      check("frame_done_f4", 32'(fd_cnt - fd0), 32'd1);
      check("sum_white", 32'(frame_sum), 32'h1EE0);
      check("pix_count_f4", 32'(pv_cnt - pv0), 32'd96);
      check("no_err_nominal", 32'(err_count), 32'd0);

      // Coloured frame, last active pixel coordinates
      send_frame(VT, -1, 1'b0);
      check("last_pix_x", 32'(last_px), 32'd11);
      check("last_pix_y", 32'(last_py), 32'd7);
      check("last_pix_rgb", 32'(last_rgb), 32'h010203);

      // Short line while locked
      fd0 = fd_cnt; le0 = le_cnt;
      send_frame(VT, 5, 1'b1);
      check("sum_colour", 32'(frame_sum), 32'h0240);
      check("frame_done_f6", 32'(fd_cnt - fd0), 32'd1);
      check("short_line_err", 32'(le_cnt - le0), 32'd1);
      check("short_line_unlock", 32'(locked), 32'd0);
      check("short_line_count", 32'(err_count), 32'd1);
      fd0 = fd_cnt;
      send_frame(VT, -1, 1'b1);
      check("no_done_dirty", 32'(fd_cnt - fd0), 32'd0);
      check("relock_wait1", 32'(locked), 32'd0);
      send_frame(VT, -1, 1'b1);
      check("relock_wait2", 32'(locked), 32'd0);
      send_frame(VT, -1, 1'b1);
      check("relocked", 32'(locked), 32'd1);

      // 11-line frame whose last line is short: both errors together
      send_frame(VT - 1, VT - 2, 1'b1);
      check("locked_short_frame", 32'(locked), 32'd1);
      le0 = le_cnt; fe0 = fe_cnt; b0 = both_cnt; fd0 = fd_cnt;
      send_frame(VT, -1, 1'b1);
      check("both_err_same_clk", 32'(both_cnt - b0), 32'd1);
      check("line_err_once", 32'(le_cnt - le0), 32'd1);
      check("frame_err_once", 32'(fe_cnt - fe0), 32'd1);
      check("err_count_plus2", 32'(err_count), 32'd3);
      check("no_done_bad_frame", 32'(fd_cnt - fd0), 32'd0);
      check("sum_held", 32'(frame_sum), 32'h1EE0);
      check("unlock_on_both", 32'(locked), 32'd0);

      // Relock, then reset mid-frame
      send_frame(VT, -1, 1'b1);
      send_frame(VT, -1, 1'b1);
      check("relock_before_rst", 32'(locked), 32'd1);
      send_frame(5, -1, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_locked", 32'(locked), 32'd0);
      check("async_rst_x", 32'(x), 32'd0);
      check("async_rst_y", 32'(y), 32'd0);
      check("async_rst_err", 32'(err_count), 32'd0);
      check("async_rst_sum", 32'(frame_sum), 32'd0);
      check("async_rst_rgb", 32'(pix_rgb), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_frame(VT, -1, 1'b1);
      send_frame(VT, -1, 1'b1);
      check("post_rst_unlocked", 32'(locked), 32'd0);
      send_frame(VT, -1, 1'b1);
      check("post_rst_locked", 32'(locked), 32'd1);
      check("post_rst_no_err", 32'(err_count), 32'd0);

      // Pixel strobe one clk in four
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      div = 4;
      send_frame(VT, -1, 1'b1);
      send_frame(VT, -1, 1'b1);
      check("div4_unlocked", 32'(locked), 32'd0);
      pv0 = pv_cnt;
      send_frame(VT, -1, 1'b1);
      check("div4_locked", 32'(locked), 32'd1);
      check("div4_pix_count", 32'(pv_cnt - pv0), 32'd96);
      fd0 = fd_cnt;
      send_frame(VT, -1, 1'b1);
      check("div4_done", 32'(fd_cnt - fd0), 32'd1);
      check("div4_sum", 32'(frame_sum), 32'h1EE0);
      check("div4_no_err", 32'(err_count), 32'd0);

      // Free-running hsync: x saturates, then errors at the next fall
      div = 1;
      for (int i = 0; i < 1100; i++) drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      check("x_saturates", 32'(x), 32'd1023);
      le0 = le_cnt; fe0 = fe_cnt;
      send_frame(VT, -1, 1'b1);
      check("sat_line_err", 32'(le_cnt - le0), 32'd1);
      check("sat_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      check("sat_err_count", 32'(err_count), 32'd1);
      check("sat_unlock", 32'(locked), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
